sprite_motion_ctrl: RTL

Frame-synchronous position controller for a 9x17 OLED sprite ROM on the 96x64 display.
- Produces the sprite's top-left x/y. The downstream sprite ROM computes y*96+x from these.
- Positions change only at frame boundaries, so the sprite never tears mid-scan.
- Three modes: manual (button-driven), bounce (autonomous, reflects off screen edges) and frozen.

---
 rtl/sprite_motion_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller for the 96x64 OLED.
// Moves the sprite only on frame boundaries: manual, bounce or frozen.
module sprite_motion_ctrl #(
  parameter int SPR_W = 9,
  parameter int SPR_H = 17,
  parameter int X0    = 43,
  parameter int Y0    = 24,
  parameter int STEP  = 2,
  parameter int SPEED = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic [1:0]  mode,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  output logic [6:0]  x,
  output logic [6:0]  y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    MANUAL,
    BOUNCE,
    FROZEN
  } state_e;

  localparam logic signed [7:0] STP = 8'(STEP);
  localparam logic signed [7:0] XMX = 8'(96 - SPR_W);
  localparam logic signed [7:0] YMX = 8'(64 - SPR_H);
  localparam logic [3:0] CNT_TOP = 4'(SPEED - 1);

  state_e      state_q, state_d, mode_st;
  logic [12:0] prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  pend_q, pend_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        tick_q, tick_d;

  logic              boundary;
  logic [3:0]        btns;
  logic signed [7:0] mx, my, bx, by;
  logic signed [7:0] cx, cy;
  logic              x_lo, x_hi, y_lo, y_hi;
  logic [6:0]        x_cl, y_cl;

  assign btns = {btn_l, btn_r, btn_u, btn_d};
  assign boundary = (pixel_index == 13'd0) && (prev_q != 13'd0);

  // Candidate positions for both modes, clamped to the screen.
  always_comb begin
    mx = 8'sd0;
    my = 8'sd0;
    if (pend_q[2] && !pend_q[3]) mx = STP;
    if (pend_q[3] && !pend_q[2]) mx = -STP;
    if (pend_q[0] && !pend_q[1]) my = STP;
    if (pend_q[1] && !pend_q[0]) my = -STP;
    bx = dx_q ? STP : -STP;
    by = dy_q ? STP : -STP;
    if (state_q == BOUNCE) begin
      cx = $signed({1'b0, x_q}) + bx;
      cy = $signed({1'b0, y_q}) + by;
    end else begin
      cx = $signed({1'b0, x_q}) + mx;
      cy = $signed({1'b0, y_q}) + my;
    end
    x_lo = cx < 8'sd0;
    x_hi = cx > XMX;
    y_lo = cy < 8'sd0;
    y_hi = cy > YMX;
    x_cl = x_lo ? 7'd0 : x_hi ? XMX[6:0] : cx[6:0];
    y_cl = y_lo ? 7'd0 : y_hi ? YMX[6:0] : cy[6:0];
  end

  // Mode decode and boundary-time next-state for all registers.
  always_comb begin
    mode_st = mode[1] ? FROZEN : (mode[0] ? BOUNCE : MANUAL);
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | btns;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    tick_d  = boundary;
    if (boundary) begin
      pend_d  = btns;
      state_d = mode_st;
      case (state_q)
        MANUAL: begin
          x_d = x_cl;
          y_d = y_cl;
        end
        BOUNCE: begin
          if (cnt_q == CNT_TOP) begin
            cnt_d = 4'd0;
            x_d   = x_cl;
            y_d   = y_cl;
            dx_d  = dx_q ^ (x_lo | x_hi);
            dy_d  = dy_q ^ (y_lo | y_hi);
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
      if (mode_st == BOUNCE && state_q != BOUNCE) cnt_d = 4'd0;
    end
  end

  // State, position and frame-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      prev_q  <= 13'd0;
      cnt_q   <= 4'd0;
      pend_q  <= 4'd0;
      x_q     <= 7'(X0);
      y_q     <= 7'(Y0);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= pixel_index;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      tick_q  <= tick_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign dir_x      = dx_q;
  assign dir_y      = dy_q;
  assign frame_tick = tick_q;

endmodule
